// File: rtl/wb_pkg.sv
// Shared types for the writeback/commit slice: register names, operand
// sizes, the buffered result record and the x86-64 partial-write merge.
package wb_pkg;

   typedef enum logic [3:0] {
      RAX, RCX, RDX, RBX, RSP, RBP, RSI, RDI,
      R8,  R9,  R10, R11, R12, R13, R14, R15
   } regname_t;

   typedef enum logic [1:0] {SZ8, SZ16, SZ32, SZ64} opsize_t;

   typedef struct packed {
      logic        nop;
      logic [3:0]  dstreg;
      logic [63:0] result;
      opsize_t     size;
   } wb_entry_t;

   // 8/16-bit writes keep the upper bits; a 32-bit write zero-extends.
   function automatic logic [63:0] merge_by_size(input logic [63:0] old_val,
                                                 input logic [63:0] new_val,
                                                 input opsize_t     size);
      logic [63:0] merged;
      case (size)
         SZ8:     merged = {old_val[63:8],  new_val[7:0]};
         SZ16:    merged = {old_val[63:16], new_val[15:0]};
         SZ32:    merged = {32'h0,          new_val[31:0]};
         default: merged = new_val;
      endcase
      return merged;
   endfunction

endpackage

// File: rtl/wb_commit_if.sv
// Execute -> writeback result handshake.
interface wb_commit_if;
   logic        wb_valid;
   logic        wb_ready;
   logic        wb_nop;
   logic [3:0]  wb_dstreg;
   logic [63:0] wb_result;
   logic [1:0]  wb_size;

   modport master (output wb_valid, wb_nop, wb_dstreg, wb_result, wb_size,
                   input  wb_ready);
   modport slave  (input  wb_valid, wb_nop, wb_dstreg, wb_result, wb_size,
                   output wb_ready);
endinterface

// File: rtl/wb_fifo.sv
// Small result FIFO between execute and commit. DEPTH must be a power of 2
// so the pointers wrap naturally.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      reset_n,
   input  logic      push,
   input  wb_entry_t din,
   input  logic      pop,
   output wb_entry_t dout,
   output logic      full,
   output logic      empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   wb_entry_t      mem [DEPTH];
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic [CW-1:0]  cnt;
   logic           do_push;
   logic           do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr];

   // Pointer and occupancy bookkeeping; a simultaneous push/pop keeps the count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Entry storage needs no reset: occupancy alone says what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: buffers execute results, commits one per cycle into
// the 16 x 64 architectural register file with x86-64 partial-write rules,
// and tracks per-register pending writes for RAW stalls in operand fetch.
// Optional macro WB_BYPASS_EN adds regx_fwd (committing entry merged in) and
// makes busy reflect the same-cycle decrement.
module wb_commit
   import wb_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int DEPTH = 2,
   parameter int CNTW  = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   wb_commit_if.slave   wb,
   input  logic         wb_hold,
   input  logic         rsv_valid,
   input  logic [3:0]   rsv_reg,
   output logic         rsv_ready,
   output logic [63:0]  regx [NREGS],
   output logic [15:0]  busy,
   output logic [63:0]  retired
`ifdef WB_BYPASS_EN
   ,output logic [63:0] regx_fwd [NREGS]
`endif
);

   wb_entry_t        in_ent;
   wb_entry_t        head;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             commit;
   logic             rsv_take;
   logic [CNTW-1:0]  cnt [NREGS];
   logic [NREGS-1:0] inc_vec;
   logic [NREGS-1:0] dec_vec;

   assign in_ent    = '{nop:    wb.wb_nop,
                        dstreg: wb.wb_dstreg,
                        result: wb.wb_result,
                        size:   opsize_t'(wb.wb_size)};
   assign wb.wb_ready = !full;
   assign push      = wb.wb_valid && !full;
   assign pop       = !empty && !wb_hold;
   assign commit    = pop && !head.nop;
   assign rsv_ready = (cnt[rsv_reg] != '1);
   assign rsv_take  = rsv_valid && rsv_ready;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .din     (in_ent),
      .pop     (pop),
      .dout    (head),
      .full    (full),
      .empty   (empty)
   );

   // Architectural register write and retire count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) regx[i] <= '0;
         retired <= '0;
      end else if (commit) begin
         regx[head.dstreg] <= merge_by_size(regx[head.dstreg], head.result, head.size);
         retired           <= retired + 64'd1;
      end
   end

   // Per-register increment/decrement requests; a decrement at zero is dropped.
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int i = 0; i < NREGS; i++) begin
         inc_vec[i] = rsv_take && (rsv_reg == 4'(i));
         dec_vec[i] = commit && (head.dstreg == 4'(i)) && (cnt[i] != '0);
      end
   end

   // Pending-write counters; increment and decrement together cancel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (inc_vec[i] && !dec_vec[i])      cnt[i] <= cnt[i] + CNTW'(1);
            else if (dec_vec[i] && !inc_vec[i]) cnt[i] <= cnt[i] - CNTW'(1);
         end
      end
   end

   // Committing to a register nobody reserved means the issue side lost track.
   always @(posedge clk) begin
      if (reset_n && commit) assert (cnt[head.dstreg] != '0);
   end

`ifdef WB_BYPASS_EN
   // Busy drops in the commit cycle of the last pending write.
   always_comb begin
      busy = '0;
      for (int i = 0; i < NREGS; i++)
         busy[i] = (cnt[i] != '0) && !(dec_vec[i] && !inc_vec[i] && (cnt[i] == CNTW'(1)));
   end

   // Register view with this cycle's committing result already merged.
   always_comb begin
      regx_fwd = regx;
      if (commit)
         regx_fwd[head.dstreg] = merge_by_size(regx[head.dstreg], head.result, head.size);
   end
`else
   // Busy from the registered counters only.
   always_comb begin
      busy = '0;
      for (int i = 0; i < NREGS; i++) busy[i] = (cnt[i] != '0);
   end
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: latency, partial writes, hold/backpressure,
// scoreboard saturation, nops and asynchronous reset.
module tb_wb_commit;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        wb_hold;
   logic        rsv_valid;
   logic [3:0]  rsv_reg;
   logic        rsv_ready;
   logic [63:0] regx [16];
   logic [15:0] busy;
   logic [63:0] retired;
`ifdef WB_BYPASS_EN
   logic [63:0] regx_fwd [16];
`endif

   int errors = 0;
   int checks = 0;

   wb_commit_if wbi ();

   always #5 clk = ~clk;

   wb_commit dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .wb        (wbi.slave),
      .wb_hold   (wb_hold),
      .rsv_valid (rsv_valid),
      .rsv_reg   (rsv_reg),
      .rsv_ready (rsv_ready),
      .regx      (regx),
      .busy      (busy),
      .retired   (retired)
`ifdef WB_BYPASS_EN
      ,.regx_fwd (regx_fwd)
`endif
   );

   typedef struct {
      logic [3:0]  dst;
      opsize_t     size;
      logic [63:0] res;
      logic [63:0] exp;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rsv(input logic [3:0] r);
      rsv_valid = 1'b1;
      rsv_reg   = r;
      cyc();
      rsv_valid = 1'b0;
   endtask

   task automatic push(input logic nop, input logic [3:0] dst,
                       input logic [63:0] res, input opsize_t sz);
      wbi.wb_valid  = 1'b1;
      wbi.wb_nop    = nop;
      wbi.wb_dstreg = dst;
      wbi.wb_result = res;
      wbi.wb_size   = sz;
      cyc();
      wbi.wb_valid  = 1'b0;
      wbi.wb_nop    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nz;

      vt[0] = '{RBX, SZ64, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      vt[1] = '{RBX, SZ8,  64'h0000_0000_0000_005A, 64'hFFFF_FFFF_FFFF_FF5A};
      vt[2] = '{RBX, SZ32, 64'h0000_0000_1234_5678, 64'h0000_0000_1234_5678};
      vt[3] = '{RBX, SZ16, 64'h0000_0000_0000_BEEF, 64'h0000_0000_1234_BEEF};
      vt[4] = '{RDX, SZ8,  64'hFFFF_FFFF_FFFF_FFAB, 64'h0000_0000_0000_00AB};
      vt[5] = '{RDX, SZ32, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000};
      vt[6] = '{RDX, SZ16, 64'hAAAA_AAAA_AAAA_1234, 64'h0000_0000_8000_1234};
      vt[7] = '{RDX, SZ64, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};

      wbi.wb_valid  = 1'b0;
      wbi.wb_nop    = 1'b0;
      wbi.wb_dstreg = '0;
      wbi.wb_result = '0;
      wbi.wb_size   = '0;
      wb_hold       = 1'b0;
      rsv_valid     = 1'b0;
      rsv_reg       = '0;

      // reset state
      #12;
      chk("rst_ready", wbi.wb_ready, 1'b1);
      chk("rst_busy", busy, 16'h0);
      chk("rst_retired", retired, 64'd0);
      chk("rst_rax", regx[RAX], 64'd0);
      cyc();
      reset_n = 1'b1;
      cyc();

      // two-edge latency into an empty FIFO
      rsv(RAX);
      push(1'b0, RAX, 64'h1122_3344_5566_7788, SZ64);
      chk("lat_edge1_rax", regx[RAX], 64'd0);
      chk("lat_edge1_busy", busy[RAX], 1'b1);
      cyc();
      chk("lat_edge2_rax", regx[RAX], 64'h1122_3344_5566_7788);
      chk("lat_retired", retired, 64'd1);
      chk("lat_busy_clr", busy[RAX], 1'b0);

      // partial-write table
      for (int i = 0; i < 8; i++) begin
         rsv(vt[i].dst);
         push(1'b0, vt[i].dst, vt[i].res, vt[i].size);
         cyc();
         chk($sformatf("vec%0d_regx", i), regx[vt[i].dst], vt[i].exp);
         chk($sformatf("vec%0d_busy", i), busy[vt[i].dst], 1'b0);
      end
      chk("vec_retired", retired, 64'd9);

      // hold: FIFO fills to 2, third waits, then drains in order
      wb_hold = 1'b1;
      rsv(R9);
      rsv(R10);
      rsv(R11);
      wbi.wb_valid = 1'b1; wbi.wb_nop = 1'b0; wbi.wb_size = SZ64;
      wbi.wb_dstreg = R9;  wbi.wb_result = 64'hAAAA_0000_0000_0009;
      chk("hold_ready0", wbi.wb_ready, 1'b1);
      cyc();
      wbi.wb_dstreg = R10; wbi.wb_result = 64'hBBBB_0000_0000_0010;
      chk("hold_ready1", wbi.wb_ready, 1'b1);
      cyc();
      wbi.wb_dstreg = R11; wbi.wb_result = 64'hCCCC_0000_0000_0011;
      chk("hold_full_ready", wbi.wb_ready, 1'b0);
      cyc();
      chk("hold_still_full", wbi.wb_ready, 1'b0);
      chk("hold_r9_frozen", regx[R9], 64'd0);
      chk("hold_retired_frozen", retired, 64'd9);
      chk("hold_busy", busy[R11:R9], 3'b111);
      wb_hold = 1'b0;
      cyc();
      chk("drain1_r9", regx[R9], 64'hAAAA_0000_0000_0009);
      chk("drain1_r10", regx[R10], 64'd0);
      chk("drain1_ready", wbi.wb_ready, 1'b1);
      cyc();
      wbi.wb_valid = 1'b0;
      chk("drain2_r10", regx[R10], 64'hBBBB_0000_0000_0010);
      chk("drain2_r11", regx[R11], 64'd0);
      cyc();
      chk("drain3_r11", regx[R11], 64'hCCCC_0000_0000_0011);
      chk("drain_retired", retired, 64'd12);
      chk("drain_busy", busy[R11:R9], 3'b000);

      // scoreboard saturation on R8
      rsv(R8);
      rsv(R8);
      rsv(R8);
      rsv_reg = R8;
      chk("sat_busy", busy[R8], 1'b1);
      chk("sat_rsv_ready", rsv_ready, 1'b0);
      rsv(R8);
      chk("sat_blocked", rsv_ready, 1'b0);
      push(1'b0, R8, 64'h8888_0000_0000_0001, SZ64);
      cyc();
      chk("sat_after_dec", rsv_ready, 1'b1);
      push(1'b0, R8, 64'h8888_0000_0000_0002, SZ64);
      rsv_valid = 1'b1;
      rsv_reg   = R8;
      cyc();
      rsv_valid = 1'b0;
      chk("incdec_rsv_ready", rsv_ready, 1'b1);
      chk("incdec_busy", busy[R8], 1'b1);
      push(1'b0, R8, 64'h8888_0000_0000_0003, SZ64);
      cyc();
      chk("cnt1_busy", busy[R8], 1'b1);
      push(1'b0, R8, 64'h8888_0000_0000_0004, SZ64);
      cyc();
      chk("cnt0_busy", busy[R8], 1'b0);
      chk("r8_final", regx[R8], 64'h8888_0000_0000_0004);
      chk("r8_retired", retired, 64'd16);

      // nops interleaved with writes to RCX
      rsv(RCX);
      rsv(RCX);
      push(1'b1, RCX, 64'hDEAD_BEEF_DEAD_BEEF, SZ64);
      cyc();
      chk("nop1_rcx", regx[RCX], 64'd0);
      chk("nop1_retired", retired, 64'd16);
      chk("nop1_busy", busy[RCX], 1'b1);
      push(1'b0, RCX, 64'h1111_1111_1111_1111, SZ64);
      cyc();
      chk("wr1_rcx", regx[RCX], 64'h1111_1111_1111_1111);
      chk("wr1_retired", retired, 64'd17);
      push(1'b1, RCX, 64'hFFFF_FFFF_FFFF_FFFF, SZ8);
      cyc();
      chk("nop2_rcx", regx[RCX], 64'h1111_1111_1111_1111);
      chk("nop2_busy", busy[RCX], 1'b1);
      push(1'b0, RCX, 64'h0000_0000_0000_0022, SZ8);
      cyc();
      chk("wr2_rcx", regx[RCX], 64'h1111_1111_1111_1122);
      chk("wr2_retired", retired, 64'd18);
      chk("wr2_busy", busy[RCX], 1'b0);
      push(1'b1, RCX, 64'h0, SZ64);
      cyc();
      rsv_reg = RCX;
      chk("nop3_busy", busy[RCX], 1'b0);
      chk("nop3_rsv_ready", rsv_ready, 1'b1);
      chk("nop3_retired", retired, 64'd18);

      // asynchronous reset with two buffered entries
      wb_hold = 1'b1;
      rsv(R12);
      rsv(R13);
      push(1'b0, R12, 64'h7777_7777_7777_7777, SZ64);
      push(1'b0, R13, 64'h6666_6666_6666_6666, SZ64);
      chk("prerst_full", wbi.wb_ready, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      nz = 0;
      for (int i = 0; i < 16; i++) if (regx[i] != 64'd0) nz++;
      chk("arst_regx_nonzero", 64'(nz), 64'd0);
      chk("arst_ready", wbi.wb_ready, 1'b1);
      chk("arst_busy", busy, 16'h0);
      chk("arst_retired", retired, 64'd0);
      wb_hold = 1'b0;
      cyc();
      reset_n = 1'b1;
      cyc();
      cyc();
      chk("post_rst_r12", regx[R12], 64'd0);
      chk("post_rst_r13", regx[R13], 64'd0);
      chk("post_rst_retired", retired, 64'd0);
      chk("post_rst_busy", busy, 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
